// File: rtl/ula_ctrl_pkg.sv
// Shared opcode encodings and ALU control decode for the ula8bit clients.
package ula_ctrl_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    // ula8bit OPERATION field
    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    typedef struct packed {
        logic       ain;
        logic       bin;
        logic       cin;
        logic [1:0] operation;
    } alu_ctrl_t;

    function automatic alu_ctrl_t decode_op(input logic [2:0] op);
        alu_ctrl_t c;
        c = '0;
        case (op)
            OP_AND:  c = '{1'b0, 1'b0, 1'b0, ALU_AND};
            OP_OR:   c = '{1'b0, 1'b0, 1'b0, ALU_OR};
            OP_ADD:  c = '{1'b0, 1'b0, 1'b0, ALU_ADD};
            OP_SUB:  c = '{1'b0, 1'b1, 1'b1, ALU_ADD};
            OP_SLT:  c = '{1'b0, 1'b1, 1'b1, ALU_SLT};
            OP_NOR:  c = '{1'b1, 1'b1, 1'b0, ALU_AND};
            OP_NAND: c = '{1'b1, 1'b1, 1'b0, ALU_OR};
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ula8bit.sv
// Shared 8-bit combinational ALU: optional operand inversion, carry-in,
// and AND/OR/ADD/SLT selection with signed-overflow of the adder.
module ula8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       AIN,
    input  logic       BIN,
    input  logic       CIN,
    input  logic [1:0] OPERATION,
    output logic [7:0] RESULT,
    output logic       OVERFLOW
);

    logic [7:0] a_eff;
    logic [7:0] b_eff;
    logic [7:0] sum;

    // Operand conditioning, adder and result select
    always_comb begin
        a_eff    = AIN ? ~A : A;
        b_eff    = BIN ? ~B : B;
        sum      = a_eff + b_eff + {7'b0, CIN};
        OVERFLOW = (a_eff[7] == b_eff[7]) && (sum[7] != a_eff[7]);
        case (OPERATION)
            2'b00:   RESULT = a_eff & b_eff;
            2'b01:   RESULT = a_eff | b_eff;
            2'b10:   RESULT = sum;
            default: RESULT = {7'b0, sum[7]};
        endcase
    end

endmodule

// File: rtl/ula_op_decode.sv
// Combinational opcode decoder: ALU controls plus illegal / overflow-valid flags.
module ula_op_decode
    import ula_ctrl_pkg::*;
(
    input  logic [2:0] op,
    output alu_ctrl_t  ctrl,
    output logic       illegal,
    output logic       ovf_valid
);

    // Opcode to ALU control mapping and qualifier flags
    always_comb begin
        ctrl      = decode_op(op);
        illegal   = (op == OP_ILL);
        ovf_valid = (op == OP_ADD) || (op == OP_SUB);
    end

endmodule

// File: rtl/ula_arbiter.sv
// Two-port round-robin front end sharing one ula8bit: one-deep execute stage
// and a held response register per port.
module ula_arbiter
    import ula_ctrl_pkg::*;
#(
    parameter int unsigned INIT_PRIO = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ_VALID0,
    input  logic       REQ_VALID1,
    output logic       REQ_READY0,
    output logic       REQ_READY1,
    input  logic [2:0] REQ_OP0,
    input  logic [2:0] REQ_OP1,
    input  logic [7:0] REQ_A0,
    input  logic [7:0] REQ_A1,
    input  logic [7:0] REQ_B0,
    input  logic [7:0] REQ_B1,
    output logic       RSP_VALID0,
    output logic       RSP_VALID1,
    input  logic       RSP_READY0,
    input  logic       RSP_READY1,
    output logic [7:0] RSP_RESULT0,
    output logic [7:0] RSP_RESULT1,
    output logic       RSP_OVF0,
    output logic       RSP_OVF1
);

    localparam logic PTR_RST = (INIT_PRIO == 0) ? 1'b1 : 1'b0;

    logic       ex_v;
    logic [2:0] ex_op;
    logic [7:0] ex_a;
    logic [7:0] ex_b;
    logic       ex_port;
    logic       last_grant;

    logic       rsp_v0, rsp_v1;
    logic [7:0] rsp_r0, rsp_r1;
    logic       rsp_o0, rsp_o1;

    logic       elig0, elig1;
    logic       grant0, grant1;

    alu_ctrl_t  ctrl;
    logic       ex_ill;
    logic       ex_ovf_ok;
    logic [7:0] alu_result;
    logic       alu_ovf;
    logic [7:0] wb_result;
    logic       wb_ovf;

    ula_op_decode u_dec (
        .op        (ex_op),
        .ctrl      (ctrl),
        .illegal   (ex_ill),
        .ovf_valid (ex_ovf_ok)
    );

    ula8bit u_alu (
        .A         (ex_a),
        .B         (ex_b),
        .AIN       (ctrl.ain),
        .BIN       (ctrl.bin),
        .CIN       (ctrl.cin),
        .OPERATION (ctrl.operation),
        .RESULT    (alu_result),
        .OVERFLOW  (alu_ovf)
    );

    // Eligibility and round-robin grant; reset forces grants low immediately
    always_comb begin
        elig0  = REQ_VALID0 && !rsp_v0 && !(ex_v && !ex_port);
        elig1  = REQ_VALID1 && !rsp_v1 && !(ex_v && ex_port);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (RST_N) begin
            if (elig0 && elig1) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    // Writeback value: illegal ops ignore the ALU, overflow only for ADD/SUB
    always_comb begin
        wb_result = ex_ill ? '0 : alu_result;
        wb_ovf    = ex_ovf_ok && !ex_ill && alu_ovf;
    end

    // Execute stage capture and last-grant pointer
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_v       <= 1'b0;
            ex_op      <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_port    <= 1'b0;
            last_grant <= PTR_RST;
        end else begin
            ex_v <= grant0 || grant1;
            if (grant0 || grant1) begin
                ex_op      <= grant1 ? REQ_OP1 : REQ_OP0;
                ex_a       <= grant1 ? REQ_A1  : REQ_A0;
                ex_b       <= grant1 ? REQ_B1  : REQ_B0;
                ex_port    <= grant1;
                last_grant <= grant1;
            end
        end
    end

    // Per-port response registers: loaded from execute, cleared on handshake
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_v0 <= 1'b0;
            rsp_r0 <= '0;
            rsp_o0 <= 1'b0;
            rsp_v1 <= 1'b0;
            rsp_r1 <= '0;
            rsp_o1 <= 1'b0;
        end else begin
            if (ex_v && !ex_port) begin
                rsp_v0 <= 1'b1;
                rsp_r0 <= wb_result;
                rsp_o0 <= wb_ovf;
            end else if (rsp_v0 && RSP_READY0) begin
                rsp_v0 <= 1'b0;
            end
            if (ex_v && ex_port) begin
                rsp_v1 <= 1'b1;
                rsp_r1 <= wb_result;
                rsp_o1 <= wb_ovf;
            end else if (rsp_v1 && RSP_READY1) begin
                rsp_v1 <= 1'b0;
            end
        end
    end

    assign REQ_READY0  = grant0;
    assign REQ_READY1  = grant1;
    assign RSP_VALID0  = rsp_v0;
    assign RSP_VALID1  = rsp_v1;
    assign RSP_RESULT0 = rsp_r0;
    assign RSP_RESULT1 = rsp_r1;
    assign RSP_OVF0    = rsp_o0;
    assign RSP_OVF1    = rsp_o1;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: inputs change on the falling edge,
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_ula_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       REQ_VALID0, REQ_VALID1;
    logic       REQ_READY0, REQ_READY1;
    logic [2:0] REQ_OP0, REQ_OP1;
    logic [7:0] REQ_A0, REQ_A1, REQ_B0, REQ_B1;
    logic       RSP_VALID0, RSP_VALID1;
    logic       RSP_READY0, RSP_READY1;
    logic [7:0] RSP_RESULT0, RSP_RESULT1;
    logic       RSP_OVF0, RSP_OVF1;

    int nvec = 0;
    int nmis = 0;

    ula_arbiter #(.INIT_PRIO(0)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .REQ_VALID0  (REQ_VALID0),
        .REQ_VALID1  (REQ_VALID1),
        .REQ_READY0  (REQ_READY0),
        .REQ_READY1  (REQ_READY1),
        .REQ_OP0     (REQ_OP0),
        .REQ_OP1     (REQ_OP1),
        .REQ_A0      (REQ_A0),
        .REQ_A1      (REQ_A1),
        .REQ_B0      (REQ_B0),
        .REQ_B1      (REQ_B1),
        .RSP_VALID0  (RSP_VALID0),
        .RSP_VALID1  (RSP_VALID1),
        .RSP_READY0  (RSP_READY0),
        .RSP_READY1  (RSP_READY1),
        .RSP_RESULT0 (RSP_RESULT0),
        .RSP_RESULT1 (RSP_RESULT1),
        .RSP_OVF0    (RSP_OVF0),
        .RSP_OVF1    (RSP_OVF1)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        REQ_VALID0 = 1'b0; REQ_VALID1 = 1'b0;
        REQ_OP0 = 3'b000;  REQ_OP1 = 3'b000;
        REQ_A0 = 8'h00; REQ_B0 = 8'h00; REQ_A1 = 8'h00; REQ_B1 = 8'h00;
        RSP_READY0 = 1'b1; RSP_READY1 = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        idle_inputs();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // One op on one port, other port idle, response ready high
    task automatic run_op(input int port, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic eo,
                          input string tag);
        @(negedge CLK);
        if (port == 0) begin
            REQ_VALID0 = 1'b1; REQ_OP0 = op; REQ_A0 = a; REQ_B0 = b;
        end else begin
            REQ_VALID1 = 1'b1; REQ_OP1 = op; REQ_A1 = a; REQ_B1 = b;
        end
        #1;
        check({tag, "_grant"}, (port == 0) ? REQ_READY0 : REQ_READY1, 8'd1);
        check({tag, "_nogrant_other"}, (port == 0) ? REQ_READY1 : REQ_READY0, 8'd0);
        @(negedge CLK);
        REQ_VALID0 = 1'b0; REQ_VALID1 = 1'b0;
        #1;
        check({tag, "_notyet"}, (port == 0) ? RSP_VALID0 : RSP_VALID1, 8'd0);
        @(negedge CLK);
        #1;
        check({tag, "_valid"}, (port == 0) ? RSP_VALID0 : RSP_VALID1, 8'd1);
        check({tag, "_result"}, (port == 0) ? RSP_RESULT0 : RSP_RESULT1, er);
        check({tag, "_ovf"}, (port == 0) ? RSP_OVF0 : RSP_OVF1, eo);
        check({tag, "_other_idle"}, (port == 0) ? RSP_VALID1 : RSP_VALID0, 8'd0);
        @(negedge CLK);
        #1;
        check({tag, "_cleared"}, (port == 0) ? RSP_VALID0 : RSP_VALID1, 8'd0);
    endtask

    logic [6:0] exp_g0;
    logic [6:0] exp_g1;

    initial begin
        RST_N = 1'b0;
        idle_inputs();
        // Reset state, with requests present to show grants are forced low
        #2;
        REQ_VALID0 = 1'b1; REQ_VALID1 = 1'b1;
        #1;
        check("rst_ready0", REQ_READY0, 8'd0);
        check("rst_ready1", REQ_READY1, 8'd0);
        check("rst_rvalid0", RSP_VALID0, 8'd0);
        check("rst_rvalid1", RSP_VALID1, 8'd0);
        check("rst_result0", RSP_RESULT0, 8'h00);
        check("rst_result1", RSP_RESULT1, 8'h00);
        check("rst_ovf0", RSP_OVF0, 8'd0);
        check("rst_ovf1", RSP_OVF1, 8'd0);
        do_reset();

        // Single-port operations
        run_op(0, 3'b010, 8'h7F, 8'h01, 8'h80, 1'b1, "add0");
        run_op(1, 3'b011, 8'h05, 8'h07, 8'hFE, 1'b0, "sub1");
        run_op(1, 3'b100, 8'h05, 8'h07, 8'h01, 1'b0, "slt1");
        run_op(0, 3'b111, 8'h12, 8'h34, 8'h00, 1'b0, "ill0");
        run_op(0, 3'b110, 8'hFF, 8'h0F, 8'hF0, 1'b0, "nand0");
        run_op(0, 3'b001, 8'hA0, 8'h05, 8'hA5, 1'b0, "or0");
        run_op(1, 3'b000, 8'h3C, 8'h0F, 8'h0C, 1'b0, "and1");
        run_op(1, 3'b100, 8'h80, 8'h01, 8'h00, 1'b0, "slt1_wrap");

        // Both ports valid every cycle: grants 0,1,-,0,1,-,0
        do_reset();
        exp_g0 = 7'b1001001;  // bit k = cycle k
        exp_g1 = 7'b0010010;
        @(negedge CLK);
        REQ_VALID0 = 1'b1; REQ_OP0 = 3'b010; REQ_A0 = 8'h01; REQ_B0 = 8'h02;
        REQ_VALID1 = 1'b1; REQ_OP1 = 3'b001; REQ_A1 = 8'h50; REQ_B1 = 8'h0A;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge CLK);
            #1;
            check($sformatf("rr_g0_c%0d", k), REQ_READY0, {7'b0, exp_g0[k]});
            check($sformatf("rr_g1_c%0d", k), REQ_READY1, {7'b0, exp_g1[k]});
            if (k == 2) check("rr_res0", RSP_RESULT0, 8'h03);
            if (k == 3) check("rr_res1", RSP_RESULT1, 8'h5A);
        end

        // Port 0 response stalled 5 cycles; port 1 keeps being served
        do_reset();
        exp_g1 = 7'b0010010;
        @(negedge CLK);
        REQ_VALID0 = 1'b1; REQ_OP0 = 3'b101; REQ_A0 = 8'hF0; REQ_B0 = 8'h0C;
        RSP_READY0 = 1'b0;
        REQ_VALID1 = 1'b1; REQ_OP1 = 3'b010; REQ_A1 = 8'h10; REQ_B1 = 8'h20;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge CLK);
            #1;
            check($sformatf("st_g1_c%0d", k), REQ_READY1, {7'b0, exp_g1[k]});
            check($sformatf("st_g0_c%0d", k), REQ_READY0, (k == 0) ? 8'd1 : 8'd0);
            if (k >= 2) begin
                check($sformatf("st_v0_c%0d", k), RSP_VALID0, 8'd1);
                check($sformatf("st_r0_c%0d", k), RSP_RESULT0, 8'h03);
            end
            if (k == 3) check("st_r1", RSP_RESULT1, 8'h30);
        end
        @(negedge CLK);
        REQ_VALID0 = 1'b0;
        RSP_READY0 = 1'b1;
        #1;
        check("st_v0_release", RSP_VALID0, 8'd1);
        @(negedge CLK);
        #1;
        check("st_v0_cleared", RSP_VALID0, 8'd0);

        // Asynchronous reset with an op in execute and port 1 holding a result
        do_reset();
        @(negedge CLK);
        REQ_VALID1 = 1'b1; REQ_OP1 = 3'b011; REQ_A1 = 8'h09; REQ_B1 = 8'h02;
        RSP_READY1 = 1'b0;
        #1;
        check("ar_g1", REQ_READY1, 8'd1);
        @(negedge CLK);
        REQ_VALID1 = 1'b0;
        @(negedge CLK);
        REQ_VALID0 = 1'b1; REQ_OP0 = 3'b010; REQ_A0 = 8'h01; REQ_B0 = 8'h01;
        #1;
        check("ar_v1_held", RSP_VALID1, 8'd1);
        check("ar_r1", RSP_RESULT1, 8'h07);
        check("ar_g0", REQ_READY0, 8'd1);
        @(negedge CLK);
        REQ_VALID1 = 1'b1;
        #1;
        RST_N = 1'b0;
        #1;
        check("ar_rv0", RSP_VALID0, 8'd0);
        check("ar_rv1", RSP_VALID1, 8'd0);
        check("ar_rr1", RSP_RESULT1, 8'h00);
        check("ar_q0", REQ_READY0, 8'd0);
        check("ar_q1", REQ_READY1, 8'd0);
        @(negedge CLK);
        #1;
        check("ar_no_wb", RSP_VALID0, 8'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("ar_first_g0", REQ_READY0, 8'd1);
        check("ar_first_g1", REQ_READY1, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
